// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller arbitrating CPU fetch and data ports onto one 32-bit SRAM.
// Optional macro SRAM_EXTRA_WAIT_EN adds a read wait state (RD3) and stretches WR_PULSE to two cycles.
//
// state    | meaning
// IDLE     | no access; accepts a request unless this is the turnaround cycle after ACK
// RD1      | read: ce_n/oe_n low, address settling
// RD2      | read: data valid (captured on exit unless RD3 is enabled)
// RD3      | read: extra wait, capture on exit (SRAM_EXTRA_WAIT_EN only)
// WR_SETUP | write: address/data/byte enables set up, we_n high
// WR_PULSE | write: we_n low (1 or 2 cycles)
// WR_HOLD  | write: we_n high, data held
// ACK      | one-cycle completion pulse on the latched port
module sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stall_o,
  output logic [19:0] sram_addr_o,
  output logic [3:0]  sram_be_n_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe_o,
  input  logic [31:0] sram_data_i
);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, RD3, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  } state_t;

`ifdef SRAM_EXTRA_WAIT_EN
  localparam logic [1:0] PULSE_LOAD = 2'd1;
`else
  localparam logic [1:0] PULSE_LOAD = 2'd0;
`endif

  state_t      state_q, state_d;
  logic        gap_q, gap_d;
  logic        is_mem_q, is_mem_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        data_oe_q, data_oe_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        rd_nxt, wr_nxt, rd_cur;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                              mem_addr_i[31:22], mem_addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mem_d = is_mem_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    gap_d    = (state_q == ACK);

    case (state_q)
      IDLE: begin
        if (!gap_q && (mem_ce_i || if_ce_i)) begin
          // Data port wins; a fetch is always a full-word read
          is_mem_d = mem_ce_i;
          addr_d   = mem_ce_i ? mem_addr_i[21:2] : if_addr_i[21:2];
          sel_d    = mem_ce_i ? mem_sel_i : 4'hF;
          wdata_d  = mem_data_i;
          state_d  = (mem_ce_i && mem_we_i) ? WR_SETUP : RD1;
        end
      end
      RD1: state_d = RD2;
`ifdef SRAM_EXTRA_WAIT_EN
      RD2: state_d = RD3;
`else
      RD2: state_d = ACK;
`endif
      RD3: state_d = ACK;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = PULSE_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == 2'd0) state_d = WR_HOLD;
        else               cnt_d   = cnt_q - 2'd1;
      end
      WR_HOLD: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad controls are registered from the next state so they never glitch
  always_comb begin
    rd_nxt    = (state_d == RD1) || (state_d == RD2) || (state_d == RD3);
    wr_nxt    = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    rd_cur    = (state_q == RD1) || (state_q == RD2) || (state_q == RD3);
    ce_n_d    = ~(rd_nxt | wr_nxt);
    oe_n_d    = ~rd_nxt;
    we_n_d    = (state_d != WR_PULSE);
    data_oe_d = wr_nxt;
    be_n_d    = 4'hF;
    if (rd_nxt)      be_n_d = 4'h0;
    else if (wr_nxt) be_n_d = ~sel_d;
    if_ack_d   = (state_d == ACK) && !is_mem_q;
    mem_ack_d  = (state_d == ACK) &&  is_mem_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    if (rd_cur && state_d == ACK) begin
      if (is_mem_q) mem_data_d = sram_data_i;
      else          if_data_d  = sram_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gap_q      <= 1'b0;
      is_mem_q   <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= 4'hF;
      data_oe_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      is_mem_q   <= is_mem_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      data_oe_q  <= data_oe_d;
      if_ack_q   <= if_ack_d;
      mem_ack_q  <= mem_ack_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign if_data_o      = if_data_q;
  assign if_ack_o       = if_ack_q;
  assign mem_data_o     = mem_data_q;
  assign mem_ack_o      = mem_ack_q;
  assign sram_addr_o    = addr_q;
  assign sram_be_n_o    = be_n_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign stall_o = rst & ((mem_ce_i & ~mem_ack_o) | (if_ce_i & ~if_ack_o));

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a small byte-lane SRAM model.
module tb_sram_ctrl;

`ifdef SRAM_EXTRA_WAIT_EN
  localparam int RD_LAT = 5, WR_LAT = 6, PW = 2, RD_LOW = 3;
`else
  localparam int RD_LAT = 4, WR_LAT = 5, PW = 1, RD_LOW = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stall_o;
  logic [19:0] sram_addr_o;
  logic [3:0]  sram_be_n_o;
  logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [31:0] sram_data_o;
  logic        sram_data_oe_o;
  logic [31:0] sram_data_i;

  logic [31:0] sram [0:255];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ack_o(mem_ack_o),
    .stall_o(stall_o), .sram_addr_o(sram_addr_o), .sram_be_n_o(sram_be_n_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_data_o(sram_data_o), .sram_data_oe_o(sram_data_oe_o), .sram_data_i(sram_data_i)
  );

  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram[sram_addr_o[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) sram[sram_addr_o[7:0]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic is_mem, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         output int ack_cyc, output int we_low, output int rd_low,
                         output logic [31:0] rdata, output logic [3:0] be_seen,
                         output logic [19:0] addr_seen, output logic ok);
    logic ack;
    if (is_mem) begin
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
    end else begin
      if_ce_i = 1'b1; if_addr_i = addr;
    end
    ack_cyc = 0; we_low = 0; rd_low = 0; rdata = '0; be_seen = 4'hF; addr_seen = '0; ok = 1'b1;
    for (int n = 1; n <= 20 && ack_cyc == 0; n++) begin
      @(negedge clk);
      if (!sram_we_n_o) begin
        we_low++; be_seen = sram_be_n_o; addr_seen = sram_addr_o;
        if (!sram_data_oe_o || sram_data_o !== wdata) ok = 1'b0;
      end
      if (!sram_ce_n_o && !sram_oe_n_o) begin
        rd_low++; addr_seen = sram_addr_o;
      end
      ack = is_mem ? mem_ack_o : if_ack_o;
      if ((is_mem ? if_ack_o : mem_ack_o) !== 1'b0) ok = 1'b0;
      if (ack) begin
        ack_cyc = n;
        rdata = is_mem ? mem_data_o : if_data_o;
        if (stall_o !== 1'b0) ok = 1'b0;
      end else if (stall_o !== 1'b1) ok = 1'b0;
    end
    @(posedge clk); #1;
    mem_ce_i = 1'b0; if_ce_i = 1'b0; mem_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int ack_c, we_l, rd_l, mack_c, iack_c, acks;
  logic [31:0] rd;
  logic [3:0] be;
  logic [19:0] ad;
  logic ok, stall_hi;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h5A00_0000 | i;
    sram[8'h04] = 32'h2402_0005;
    sram[8'h41] = 32'h0123_4567;
    sram[8'h80] = 32'hDEAD_BEEF;
    sram[8'h50] = 32'h1122_3344;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", {31'b0, sram_ce_n_o}, 32'h1);
    chk("rst_oe_n", {31'b0, sram_oe_n_o}, 32'h1);
    chk("rst_we_n", {31'b0, sram_we_n_o}, 32'h1);
    chk("rst_be_n", {28'b0, sram_be_n_o}, 32'hF);
    chk("rst_data_oe", {31'b0, sram_data_oe_o}, 32'h0);
    chk("rst_addr", {12'b0, sram_addr_o}, 32'h0);
    chk("rst_acks", {30'b0, if_ack_o, mem_ack_o}, 32'h0);
    chk("rst_if_data", if_data_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Fetch of word 4
    run_txn(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, ack_c, we_l, rd_l, rd, be, ad, ok);
    chk("fetch_ack_cyc", ack_c, RD_LAT);
    chk("fetch_data", rd, 32'h2402_0005);
    chk("fetch_rd_cycles", rd_l, RD_LOW);
    chk("fetch_addr", {12'b0, ad}, 32'h4);
    chk("fetch_we_cycles", we_l, 0);
    chk("fetch_stall_ack", {31'b0, ok}, 32'h1);

    // Byte-lane write, lane 1
    run_txn(1'b1, 1'b1, 32'h0000_0104, 4'b0010, 32'hAABB_CCDD, ack_c, we_l, rd_l, rd, be, ad, ok);
    chk("bwr_ack_cyc", ack_c, WR_LAT);
    chk("bwr_we_cycles", we_l, PW);
    chk("bwr_be_n", {28'b0, be}, 32'hD);
    chk("bwr_addr", {12'b0, ad}, 32'h41);
    chk("bwr_word", sram[8'h41], 32'h0123_CC67);
    chk("bwr_bus_ok", {31'b0, ok}, 32'h1);

    // Write with no lanes selected: sequence runs, memory untouched
    run_txn(1'b1, 1'b1, 32'h0000_0104, 4'b0000, 32'h9999_9999, ack_c, we_l, rd_l, rd, be, ad, ok);
    chk("sel0_ack_cyc", ack_c, WR_LAT);
    chk("sel0_we_cycles", we_l, PW);
    chk("sel0_be_n", {28'b0, be}, 32'hF);
    chk("sel0_word", sram[8'h41], 32'h0123_CC67);

    // Full-word write then data read-back
    run_txn(1'b1, 1'b1, 32'h0000_0300, 4'hF, 32'hCAFE_F00D, ack_c, we_l, rd_l, rd, be, ad, ok);
    chk("fwr_be_n", {28'b0, be}, 32'h0);
    chk("fwr_word", sram[8'hC0], 32'hCAFE_F00D);
    run_txn(1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0, ack_c, we_l, rd_l, rd, be, ad, ok);
    chk("mrd_ack_cyc", ack_c, RD_LAT);
    chk("mrd_data", rd, 32'hCAFE_F00D);
    chk("mrd_ok", {31'b0, ok}, 32'h1);

    // Contention: data read of 0x200 and fetch of 0x10 together
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200; mem_sel_i = 4'h0;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    mack_c = 0; iack_c = 0; stall_hi = 1'b1;
    for (int n = 1; n <= 30 && iack_c == 0; n++) begin
      @(negedge clk);
      if (mem_ack_o) begin
        mack_c = n;
        chk("cont_mem_data", mem_data_o, 32'hDEAD_BEEF);
      end
      if (if_ack_o) begin
        iack_c = n;
        chk("cont_if_data", if_data_o, 32'h2402_0005);
      end else if (!stall_o) stall_hi = 1'b0;
      if (mem_ack_o) begin
        @(posedge clk); #1 mem_ce_i = 1'b0;
      end
    end
    @(posedge clk); #1 if_ce_i = 1'b0;
    chk("cont_mem_ack_cyc", mack_c, RD_LAT);
    chk("cont_if_ack_cyc", iack_c, 2 * RD_LAT + 1);
    chk("cont_stall_high", {31'b0, stall_hi}, 32'h1);
    repeat (2) @(posedge clk); #1;

    // Reset during WR_PULSE aborts with no ack
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0140; mem_sel_i = 4'b0001;
    mem_data_i = 32'h0000_00EE;
    we_l = 0;
    for (int n = 1; n <= 12 && we_l == 0; n++) begin
      @(negedge clk);
      if (!sram_we_n_o) we_l = n;
    end
    chk("rstp_reached_pulse", {31'b0, (we_l != 0)}, 32'h1);
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstp_we_n", {31'b0, sram_we_n_o}, 32'h1);
    chk("rstp_ce_n", {31'b0, sram_ce_n_o}, 32'h1);
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      if (mem_ack_o || if_ack_o) acks++;
      @(negedge clk);
    end
    chk("rstp_no_ack", acks, 0);
    chk("rstp_idle_ce_n", {31'b0, sram_ce_n_o}, 32'h1);
    chk("rstp_upper_bytes", {8'b0, sram[8'h50][31:8]}, 32'h0011_2233);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
